// File: rtl/mdpx_packet_framer_if.sv
`timescale 1ns/1ps
// Byte-stream input and framed-output handshake of the Medipix packet framer.
// The framer connects to the slave modport; the data source and sink side uses master.
interface mdpx_packet_framer_if;
   logic        In_Sync;
   logic        In_Valid;
   logic [7:0]  In_Data;
   logic [15:0] In_Packet_Length;
   logic        In_Ready;
   logic        Out_Valid;
   logic        Out_Sop;
   logic        Out_Eop;
   logic [7:0]  Out_Data;
   logic [15:0] Out_Err_Count;
   logic [15:0] Out_Seq;

   modport master (
      output In_Sync, In_Valid, In_Data, In_Packet_Length, In_Ready,
      input  Out_Valid, Out_Sop, Out_Eop, Out_Data, Out_Err_Count, Out_Seq
   );

   modport slave (
      input  In_Sync, In_Valid, In_Data, In_Packet_Length, In_Ready,
      output Out_Valid, Out_Sop, Out_Eop, Out_Data, Out_Err_Count, Out_Seq
   );
endinterface

// File: rtl/mdpx_packet_framer.sv
`timescale 1ns/1ps
// Store-and-forward framer: buffers whole readout packets, emits header + payload.
// Define MDPX_FRAMER_CHECKSUM_EN to append an XOR checksum trailer byte.
module mdpx_packet_framer #(
   parameter int DEPTH_LOG2    = 11,
   parameter int LEN_FIFO_LOG2 = 2
) (
   input  logic                 In_Clk,
   input  logic                 In_Reset,
   mdpx_packet_framer_if.slave  link
);
   localparam int BUF_BYTES = 1 << DEPTH_LOG2;
   localparam int Q_DEPTH   = 1 << LEN_FIFO_LOG2;
   localparam logic [16:0] BUF_LIMIT = 17'(BUF_BYTES);
   localparam logic [LEN_FIFO_LOG2:0] Q_ONE  = 1;
   localparam logic [LEN_FIFO_LOG2:0] Q_FULL = Q_DEPTH[LEN_FIFO_LOG2:0];
   localparam logic [DEPTH_LOG2-1:0]  P_ONE  = 1;

   typedef enum logic [2:0] {IDLE, H0, H1, H2, H3, PAY, CSUM} state_t;

   logic [7:0]  mem [BUF_BYTES];
   logic [7:0]  rd_data;
   logic [15:0] q_len [Q_DEPTH];

   logic                   active_reg, active_next;
   logic [15:0]            len_reg, len_next, cnt_reg, cnt_next;
   logic [DEPTH_LOG2-1:0]  wr_ptr_reg, wr_ptr_next, commit_ptr_reg, commit_ptr_next;
   logic [DEPTH_LOG2-1:0]  rd_ptr_reg, rd_ptr_next;
   logic [DEPTH_LOG2:0]    used_reg, used_next;
   logic [15:0]            err_reg, err_next, seq_reg, seq_next;
   logic [15:0]            pay_cnt_reg, pay_cnt_next;
   logic [LEN_FIFO_LOG2-1:0] q_wr_reg, q_rd_reg;
   logic [LEN_FIFO_LOG2:0] q_cnt_reg;
   state_t                 state_reg, state_next;

   logic                   wr_en, commit, pop, q_full, len_ok, last_pay;
   logic [DEPTH_LOG2-1:0]  wr_addr;
   logic [15:0]            commit_len, head_len;
   logic [1:0]             err_inc;
   logic [16:0]            free_bytes, err_sum;
   logic                   out_valid, out_sop, out_eop;
   logic [7:0]             out_data;

   assign q_full     = (q_cnt_reg == Q_FULL);
   assign head_len   = q_len[q_rd_reg];
   assign free_bytes = BUF_LIMIT - 17'(used_reg);
   assign len_ok     = (link.In_Packet_Length != 16'd0)
                    && ({1'b0, link.In_Packet_Length} <= BUF_LIMIT)
                    && ({1'b0, link.In_Packet_Length} <= free_bytes);

   // Write side: a packet is written tentatively from the commit pointer and only
   // becomes visible to the reader once its final byte lands.
   always_comb begin
      active_next = active_reg;
      len_next    = len_reg;
      cnt_next    = cnt_reg;
      wr_ptr_next = wr_ptr_reg;
      wr_en       = 1'b0;
      wr_addr     = wr_ptr_reg;
      commit      = 1'b0;
      commit_len  = len_reg;
      err_inc     = 2'd0;
      if (link.In_Valid && link.In_Sync) begin
         if (active_reg) err_inc = err_inc + 2'd1;
         if (len_ok) begin
            wr_en       = 1'b1;
            wr_addr     = commit_ptr_reg;
            wr_ptr_next = commit_ptr_reg + P_ONE;
            active_next = 1'b1;
            len_next    = link.In_Packet_Length;
            commit_len  = link.In_Packet_Length;
            cnt_next    = 16'd1;
         end else begin
            active_next = 1'b0;
            err_inc     = err_inc + 2'd1;
         end
      end else if (link.In_Valid && active_reg) begin
         wr_en       = 1'b1;
         wr_ptr_next = wr_ptr_reg + P_ONE;
         cnt_next    = cnt_reg + 16'd1;
      end
      if (active_next && (cnt_next == len_next)) begin
         active_next = 1'b0;
         if (q_full) err_inc = err_inc + 2'd1;
         else        commit  = 1'b1;
      end
   end

   assign commit_ptr_next = commit ? wr_ptr_next : commit_ptr_reg;
   assign used_next = used_reg + (commit ? commit_len[DEPTH_LOG2:0] : '0)
                               - (pop ? head_len[DEPTH_LOG2:0] : '0);
   assign err_sum  = {1'b0, err_reg} + 17'(err_inc);
   assign err_next = err_sum[16] ? 16'hFFFF : err_sum[15:0];
   assign last_pay = (pay_cnt_reg == head_len - 16'd1);

`ifdef MDPX_FRAMER_CHECKSUM_EN
   logic [7:0] csum_reg, csum_next;
   always_comb begin
      csum_next = csum_reg;
      if (state_reg == IDLE)
         csum_next = 8'h00;
      else if (out_valid && link.In_Ready && state_reg != CSUM)
         csum_next = csum_reg ^ out_data;
   end
   always_ff @(posedge In_Clk or posedge In_Reset) begin
      if (In_Reset) csum_reg <= 8'h00;
      else          csum_reg <= csum_next;
   end
`endif

   // Read FSM; rd_ptr always names the byte PAY will present, so the RAM read
   // issued from rd_ptr_next is ready one cycle ahead and held during stalls.
   always_comb begin
      state_next   = state_reg;
      pay_cnt_next = pay_cnt_reg;
      rd_ptr_next  = rd_ptr_reg;
      seq_next     = seq_reg;
      pop          = 1'b0;
      out_valid    = 1'b0;
      out_sop      = 1'b0;
      out_eop      = 1'b0;
      out_data     = 8'h00;
      case (state_reg)
         IDLE: begin
            pay_cnt_next = 16'd0;
            if (q_cnt_reg != '0) state_next = H0;
         end
         H0: begin
            out_valid = 1'b1;
            out_sop   = 1'b1;
            out_data  = seq_reg[15:8];
            if (link.In_Ready) state_next = H1;
         end
         H1: begin
            out_valid = 1'b1;
            out_data  = seq_reg[7:0];
            if (link.In_Ready) state_next = H2;
         end
         H2: begin
            out_valid = 1'b1;
            out_data  = head_len[15:8];
            if (link.In_Ready) state_next = H3;
         end
         H3: begin
            out_valid = 1'b1;
            out_data  = head_len[7:0];
            if (link.In_Ready) state_next = PAY;
         end
         PAY: begin
            out_valid = 1'b1;
            out_data  = rd_data;
`ifndef MDPX_FRAMER_CHECKSUM_EN
            out_eop   = last_pay;
`endif
            if (link.In_Ready) begin
               rd_ptr_next  = rd_ptr_reg + P_ONE;
               pay_cnt_next = pay_cnt_reg + 16'd1;
               if (last_pay) begin
`ifdef MDPX_FRAMER_CHECKSUM_EN
                  state_next = CSUM;
`else
                  state_next = IDLE;
                  pop        = 1'b1;
`endif
               end
            end
         end
`ifdef MDPX_FRAMER_CHECKSUM_EN
         CSUM: begin
            out_valid = 1'b1;
            out_eop   = 1'b1;
            out_data  = csum_reg;
            if (link.In_Ready) begin
               state_next = IDLE;
               pop        = 1'b1;
            end
         end
`endif
         default: state_next = IDLE;
      endcase
      if (pop) seq_next = seq_reg + 16'd1;
   end

   always_ff @(posedge In_Clk) begin
      if (wr_en) mem[wr_addr] <= link.In_Data;
      rd_data <= mem[rd_ptr_next];
   end

   always_ff @(posedge In_Clk) begin
      if (commit) q_len[q_wr_reg] <= commit_len;
   end

   always_ff @(posedge In_Clk or posedge In_Reset) begin
      if (In_Reset) begin
         active_reg     <= 1'b0;
         len_reg        <= '0;
         cnt_reg        <= '0;
         wr_ptr_reg     <= '0;
         commit_ptr_reg <= '0;
         rd_ptr_reg     <= '0;
         used_reg       <= '0;
         err_reg        <= '0;
         seq_reg        <= '0;
         pay_cnt_reg    <= '0;
         q_wr_reg       <= '0;
         q_rd_reg       <= '0;
         q_cnt_reg      <= '0;
         state_reg      <= IDLE;
      end else begin
         active_reg     <= active_next;
         len_reg        <= len_next;
         cnt_reg        <= cnt_next;
         wr_ptr_reg     <= wr_ptr_next;
         commit_ptr_reg <= commit_ptr_next;
         rd_ptr_reg     <= rd_ptr_next;
         used_reg       <= used_next;
         err_reg        <= err_next;
         seq_reg        <= seq_next;
         pay_cnt_reg    <= pay_cnt_next;
         state_reg      <= state_next;
         if (commit) q_wr_reg <= q_wr_reg + 1'b1;
         if (pop)    q_rd_reg <= q_rd_reg + 1'b1;
         case ({commit, pop})
            2'b10:   q_cnt_reg <= q_cnt_reg + Q_ONE;
            2'b01:   q_cnt_reg <= q_cnt_reg - Q_ONE;
            default: q_cnt_reg <= q_cnt_reg;
         endcase
      end
   end

   assign link.Out_Valid     = out_valid;
   assign link.Out_Sop       = out_sop;
   assign link.Out_Eop       = out_eop;
   assign link.Out_Data      = out_data;
   assign link.Out_Err_Count = err_reg;
   assign link.Out_Seq       = seq_reg;
endmodule

// File: tb/tb_mdpx_packet_framer.sv
`timescale 1ns/1ps
// Directed bench for mdpx_packet_framer; frame trailer length follows
// MDPX_FRAMER_CHECKSUM_EN so the same vectors cover both builds.
module tb_mdpx_packet_framer;
   logic clk = 1'b0;
   logic rst;
   always #50 clk = ~clk;

   mdpx_packet_framer_if bus();

   mdpx_packet_framer #(.DEPTH_LOG2(11), .LEN_FIFO_LOG2(2)) dut (
      .In_Clk   (clk),
      .In_Reset (rst),
      .link     (bus)
   );

`ifdef MDPX_FRAMER_CHECKSUM_EN
   localparam int TRL = 5;
`else
   localparam int TRL = 4;
`endif

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int ready_mode = 0;
   int last_cyc;
   logic [7:0] cap_data[$];
   logic       cap_sop[$];
   logic       cap_eop[$];
   int         cap_cyc[$];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!rst && bus.Out_Valid && bus.In_Ready) begin
         cap_data.push_back(bus.Out_Data);
         cap_sop.push_back(bus.Out_Sop);
         cap_eop.push_back(bus.Out_Eop);
         cap_cyc.push_back(cyc);
         if (bus.Out_Eop)
            $display("frame seq=%0d ends at cycle %0d, %0d bytes captured so far",
                     bus.Out_Seq, cyc, cap_data.size());
      end
   end

   // In_Ready pattern: 0 = always high, 1 = toggle every cycle, 2 = held low.
   initial begin
      bus.In_Ready = 1'b0;
      forever begin
         @(posedge clk); #1;
         case (ready_mode)
            0:       bus.In_Ready = 1'b1;
            1:       bus.In_Ready = ~bus.In_Ready;
            default: bus.In_Ready = 1'b0;
         endcase
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic s, input logic v, input logic [7:0] d, input logic [15:0] l);
      bus.In_Sync = s;
      bus.In_Valid = v;
      bus.In_Data = d;
      bus.In_Packet_Length = l;
      @(posedge clk); #1;
   endtask

   task automatic send_pkt(input logic [15:0] len, input int n, input logic [7:0] b0,
                           input logic [7:0] step);
      for (int i = 0; i < n; i++) begin
         if (i == n - 1) last_cyc = cyc;
         drive(i == 0, 1'b1, b0 + 8'(i) * step, len);
      end
      bus.In_Sync = 1'b0;
      bus.In_Valid = 1'b0;
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.In_Sync = 1'b0;
      bus.In_Valid = 1'b0;
      bus.In_Data = 8'h00;
      bus.In_Packet_Length = 16'd0;
      ready_mode = 0;
      wait_cycles(3);
      cap_data.delete();
      cap_sop.delete();
      cap_eop.delete();
      cap_cyc.delete();
      rst = 1'b0;
      wait_cycles(1);
   endtask

   task automatic check_frame(input string tag, input int base, input logic [15:0] seq,
                              input logic [15:0] len, input logic [7:0] b0);
      logic [7:0] exp_q[$];
      logic [7:0] x;
      exp_q = {seq[15:8], seq[7:0], len[15:8], len[7:0]};
      for (int i = 0; i < int'(len); i++) exp_q.push_back(b0 + 8'(i));
`ifdef MDPX_FRAMER_CHECKSUM_EN
      x = 8'h00;
      foreach (exp_q[i]) x = x ^ exp_q[i];
      exp_q.push_back(x);
`endif
      if (cap_data.size() < base + exp_q.size()) begin
         chk({tag, " captured"}, 32'(cap_data.size()), 32'(base + exp_q.size()));
         return;
      end
      foreach (exp_q[i]) begin
         chk($sformatf("%s data[%0d]", tag, i), 32'(cap_data[base+i]), 32'(exp_q[i]));
         chk($sformatf("%s sop[%0d]", tag, i), 32'(cap_sop[base+i]), 32'(i == 0));
         chk($sformatf("%s eop[%0d]", tag, i), 32'(cap_eop[base+i]), 32'(i == exp_q.size() - 1));
      end
   endtask

   initial begin
      rst = 1'b1;
      do_reset();
      chk("reset valid", 32'(bus.Out_Valid), 0);
      chk("reset sop", 32'(bus.Out_Sop), 0);
      chk("reset eop", 32'(bus.Out_Eop), 0);
      chk("reset data", 32'(bus.Out_Data), 0);
      chk("reset err", 32'(bus.Out_Err_Count), 0);
      chk("reset seq", 32'(bus.Out_Seq), 0);

      // Single L=4 packet 11 22 33 44.
      send_pkt(16'd4, 4, 8'h11, 8'h11);
      wait_cycles(60);
      chk("t1 count", 32'(cap_data.size()), 32'(4 + TRL));
      begin
         logic [7:0] e1[$];
         e1 = {8'h00, 8'h00, 8'h00, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44};
`ifdef MDPX_FRAMER_CHECKSUM_EN
         e1.push_back(8'h40);
`endif
         foreach (e1[i]) chk($sformatf("t1 data[%0d]", i), 32'(cap_data[i]), 32'(e1[i]));
      end
      chk("t1 sop", 32'(cap_sop[0]), 1);
      chk("t1 eop", 32'(cap_eop[3 + TRL]), 1);
      chk("t1 latency", 32'(cap_cyc[0] - last_cyc), 2);
      chk("t1 rate", 32'(cap_cyc[3 + TRL] - cap_cyc[0]), 32'(3 + TRL));
      chk("t1 seq", 32'(bus.Out_Seq), 1);
      chk("t1 idle", 32'(bus.Out_Valid), 0);

      // Two L=3 packets back to back.
      do_reset();
      send_pkt(16'd3, 3, 8'hA1, 8'h01);
      send_pkt(16'd3, 3, 8'hB1, 8'h01);
      wait_cycles(60);
      chk("t2 count", 32'(cap_data.size()), 32'(2 * (3 + TRL)));
      check_frame("t2 f0", 0, 16'd0, 16'd3, 8'hA1);
      check_frame("t2 f1", 3 + TRL, 16'd1, 16'd3, 8'hB1);
      chk("t2 gap", 32'(cap_cyc[3 + TRL] - cap_cyc[2 + TRL]), 2);
      chk("t2 err", 32'(bus.Out_Err_Count), 0);
      chk("t2 seq", 32'(bus.Out_Seq), 2);

      // L=5 cut short by a new sync with L=2.
      do_reset();
      send_pkt(16'd5, 3, 8'h51, 8'h01);
      send_pkt(16'd2, 2, 8'hC1, 8'h01);
      wait_cycles(60);
      chk("t3 err", 32'(bus.Out_Err_Count), 1);
      chk("t3 count", 32'(cap_data.size()), 32'(2 + TRL));
      check_frame("t3 f0", 0, 16'd0, 16'd2, 8'hC1);
      chk("t3 seq", 32'(bus.Out_Seq), 1);

      // Oversize then zero-length packets.
      do_reset();
      send_pkt(16'd3000, 4, 8'h10, 8'h01);
      wait_cycles(30);
      chk("t4 err oversize", 32'(bus.Out_Err_Count), 1);
      chk("t4 count oversize", 32'(cap_data.size()), 0);
      send_pkt(16'd0, 1, 8'h20, 8'h01);
      wait_cycles(30);
      chk("t4 err zero", 32'(bus.Out_Err_Count), 2);
      chk("t4 count zero", 32'(cap_data.size()), 0);
      chk("t4 valid", 32'(bus.Out_Valid), 0);

      // L=8 with In_Ready toggling.
      do_reset();
      ready_mode = 1;
      send_pkt(16'd8, 8, 8'h81, 8'h01);
      wait_cycles(80);
      chk("t5 count", 32'(cap_data.size()), 32'(8 + TRL));
      check_frame("t5 f0", 0, 16'd0, 16'd8, 8'h81);
      chk("t5 seq", 32'(bus.Out_Seq), 1);

      // Five L=16 packets while stalled: the fifth overflows the descriptor queue.
      do_reset();
      ready_mode = 2;
      for (int k = 0; k < 5; k++) send_pkt(16'd16, 16, 8'(k * 32), 8'h01);
      wait_cycles(20);
      chk("t6 err", 32'(bus.Out_Err_Count), 1);
      chk("t6 stalled count", 32'(cap_data.size()), 0);
      chk("t6 stalled valid", 32'(bus.Out_Valid), 1);
      chk("t6 stalled sop", 32'(bus.Out_Sop), 1);
      ready_mode = 0;
      wait_cycles(200);
      chk("t6 count", 32'(cap_data.size()), 32'(4 * (16 + TRL)));
      for (int k = 0; k < 4; k++)
         check_frame($sformatf("t6 f%0d", k), k * (16 + TRL), 16'(k), 16'd16, 8'(k * 32));
      chk("t6 seq", 32'(bus.Out_Seq), 4);
      chk("t6 err final", 32'(bus.Out_Err_Count), 1);

      // Reset in the middle of a stalled frame.
      ready_mode = 2;
      send_pkt(16'd2, 2, 8'hE1, 8'h01);
      wait_cycles(5);
      rst = 1'b1;
      wait_cycles(1);
      chk("t7 reset valid", 32'(bus.Out_Valid), 0);
      chk("t7 reset seq", 32'(bus.Out_Seq), 0);
      chk("t7 reset err", 32'(bus.Out_Err_Count), 0);
      rst = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
